// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: decode/execute hazard control for the 16-bit pipeline.
// Handles multi-cycle load-use stalls, a single outstanding mul/div result
// tracked by a one-entry scoreboard (RAW and structural stalls), and
// branch-taken flush. Flush always wins over stall, because the instruction
// sitting in decode is being squashed anyway.
module hazard_unit_sb #(
    parameter int REG_W      = 4,
    parameter int LOAD_STALL = 1,
    parameter int MD_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] idRs1,
    input  logic [REG_W-1:0] idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic [REG_W-1:0] idRd,
    input  logic             idIsMulDiv,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRd,
    input  logic             branchTaken,
    output logic             stall,
    output logic             ifidWrite,
    output logic             pcWrite,
    output logic             flush,
    output logic             mdBusy
);

    // loadCnt holds the bubbles still owed after the detection cycle, so it
    // only has to reach LOAD_STALL-1; mdCnt only has to reach MD_LATENCY-1.
    localparam int LCW = $clog2(LOAD_STALL + 1);
    localparam int MCW = $clog2(MD_LATENCY);

    localparam logic [LCW-1:0] LOAD_RELOAD = LCW'(LOAD_STALL - 1);
    localparam logic [LCW-1:0] LOAD_ONE    = LCW'(1);
    localparam logic [MCW-1:0] MD_RELOAD   = MCW'(MD_LATENCY - 1);
    localparam logic [MCW-1:0] MD_ONE      = MCW'(1);

    logic [LCW-1:0]   loadCnt;
    logic [MCW-1:0]   mdCnt;
    logic [REG_W-1:0] mdDest;

    logic loadHit;
    logic mdSrcHit;
    logic mdHit;
    logic rawStall;
    logic mdIssue;

    // Hazard detection and output steering; everything here is same-cycle.
    always_comb begin
        loadHit  = exMemRead &&
                   ((idUsesRs1 && (idRs1 == exRd)) ||
                    (idUsesRs2 && (idRs2 == exRd)));
        mdSrcHit = (idUsesRs1 && (idRs1 == mdDest)) ||
                   (idUsesRs2 && (idRs2 == mdDest));
        mdBusy   = (mdCnt != '0);
        mdHit    = mdBusy && (mdSrcHit || idIsMulDiv);
        rawStall = loadHit || (loadCnt != '0) || mdHit;
        stall    = rawStall && !branchTaken;
        flush    = branchTaken;
        ifidWrite = !stall;
        pcWrite   = !stall;
        mdIssue   = idIsMulDiv && !stall && !branchTaken;
    end

    // Load-use bubble counter: arm on a fresh hit, drain otherwise, and drop
    // everything on a taken branch since the dependent instruction is squashed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loadCnt <= '0;
        end else if (branchTaken) begin
            loadCnt <= '0;
        end else if (loadHit && (loadCnt == '0)) begin
            loadCnt <= LOAD_RELOAD;
        end else if (loadCnt != '0) begin
            loadCnt <= loadCnt - LOAD_ONE;
        end
    end

    // Mul/div scoreboard entry: a branch never cancels it, the op is older.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdCnt  <= '0;
            mdDest <= '0;
        end else if (mdIssue) begin
            mdCnt  <= MD_RELOAD;
            mdDest <= idRd;
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - MD_ONE;
        end
    end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Parametrised successor to the single-cycle load-use hazard detector for the 16-bit pipeline. It sits between the decode and execute stages and drives the PC write enable, the IF/ID write enable, the ID/EX bubble (stall) and the IF/ID flush. It adds three things the previous unit lacked:
- Multi-cycle load-use stalls, for configurable memory latency.
- A one-entry scoreboard for multi-cycle mul/div results, with RAW and structural stalls.
- Branch-taken flush with defined priority over stalls.

Parameters:
REG_W, 4, register address width
LOAD_STALL, 1, bubbles inserted per load-use hazard (>=1)
MD_LATENCY, 4, cycles from mul/div issue until its result is forwardable (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
idRs1  in  REG_W  decode source register 1
idRs2  in  REG_W  decode source register 2
idUsesRs1  in  1  decode instruction reads idRs1
idUsesRs2  in  1  decode instruction reads idRs2
idRd  in  REG_W  decode destination register
idIsMulDiv  in  1  decode instruction is a mul/div
exMemRead  in  1  execute-stage instruction is a load
exRd  in  REG_W  execute-stage load destination
branchTaken  in  1  execute stage resolved a taken branch
stall  out  1  1 = inject bubble into ID/EX
ifidWrite  out  1  1 = IF/ID register may load
pcWrite  out  1  1 = PC may update
flush  out  1  1 = clear IF/ID (squash decode instruction)
mdBusy  out  1  mul/div result outstanding

Behaviour:
- Reset (rst=0, async): loadCnt=0, mdCnt=0, mdDest=0. With idle inputs the outputs are stall=0, ifidWrite=1, pcWrite=1, flush=0, mdBusy=0. Reset mid-operation discards any pending stall or mul/div state immediately.
- Source match: srcHit(r) = (idUsesRs1 && idRs1==r) || (idUsesRs2 && idRs2==r). Register 0 gets no special treatment.
- Load-use hit: loadHit = exMemRead && srcHit(exRd).
- Mul/div tracking:
  - mdBusy = (mdCnt != 0).
  - mdHit = mdBusy && (srcHit(mdDest) || idIsMulDiv). The idIsMulDiv term is the structural case: only one outstanding mul/div.
- Combinational outputs, same cycle:
  - flush = branchTaken.
  - rawStall = loadHit || (loadCnt != 0) || mdHit.
  - stall = rawStall && !branchTaken. Flush has priority; the squashed instruction must not stall.
  - ifidWrite = pcWrite = !stall.
- loadCnt (width $clog2(LOAD_STALL+1)), per clock:
  - If branchTaken: loadCnt <= 0.
  - Else if loadHit && loadCnt==0: loadCnt <= LOAD_STALL-1.
  - Else if loadCnt!=0: loadCnt <= loadCnt-1.
  - Result: a load-use hazard yields exactly LOAD_STALL consecutive stall cycles, starting in the detection cycle.
- mdCnt (width $clog2(MD_LATENCY)) and mdDest, per clock:
  - Issue = idIsMulDiv && !stall && !branchTaken.
  - On issue: mdCnt <= MD_LATENCY-1, mdDest <= idRd.
  - Else if mdCnt!=0: mdCnt <= mdCnt-1.
  - Mul/div issued at cycle t gives mdBusy=1 for cycles t+1 .. t+MD_LATENCY-1.
  - branchTaken does not cancel an already-issued mul/div; it is older than the branch.
- Simultaneous events:
  - loadHit and mdHit together: a single stall. Both counters continue independently, and the stall lasts until both clear.
  - Issue while mdCnt==1 is illegal, since mdHit already stalls it. The bench checks that it never occurs.
- No X on outputs after reset, for any input values.

Test Plan:
- LOAD_STALL=2: exMemRead=1, exRd=3, idRs1=3, idUsesRs1=1, then exMemRead=0 -> stall=1, pcWrite=ifidWrite=0 for exactly 2 cycles, then stall=0.
- Load to R3 while decode reads R5 (idRs1=5, idRs2=3 with idUsesRs2=0) -> stall stays 0; checks the use-flag gating.
- MD_LATENCY=4: mul/div issued at t with idRd=7; decode at t+1 reads R7 -> mdBusy=1 and stall=1 at t+1..t+3; stall=0 and mdBusy=0 at t+4. A second mul/div at t+1 stalls identically (structural).
- LOAD_STALL=3: hazard detected at t; branchTaken=1 at t+1 -> flush=1, stall=0, pcWrite=1 at t+1; loadCnt=0 and stall=0 at t+2.
- Mul/div issued (mdBusy=1), rst pulsed low asynchronously mid-cycle -> mdBusy=0 and stall=0 immediately, with no clock edge required. After release, a dependent read of the old mdDest -> stall=0.
- Load hit and mdHit in the same cycle (LOAD_STALL=1, MD_LATENCY=3) -> stall held until both clear; a single contiguous stall window.
